// File: rtl/hazard_pkg.sv
// Shared encodings and parameter defaults for the scoreboard hazard unit.
package hazard_pkg;

  localparam int unsigned REG_COUNT_DEF    = 32;
  localparam int unsigned REG_ADDR_W_DEF   = 5;
  localparam int unsigned LOAD_LATENCY_DEF = 1;
  localparam int unsigned FLUSH_CYCLES_DEF = 1;
  localparam int unsigned STALL_CNT_W_DEF  = 16;

  localparam int unsigned SB_CNT_W = 3;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEQ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;
  localparam logic [1:0] BR_JUMP = 2'b11;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register pending-load countdowns; busy while a countdown is nonzero.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_COUNT    = REG_COUNT_DEF,
  parameter int unsigned REG_ADDR_W   = REG_ADDR_W_DEF,
  parameter int unsigned LOAD_LATENCY = LOAD_LATENCY_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_en,
  input  logic [REG_ADDR_W-1:0] load_rd,
  output logic [REG_COUNT-1:0]  busy
);

  logic [SB_CNT_W-1:0] count [REG_COUNT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) count[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        if (i == 0)
          count[i] <= '0;
        else if (load_en && load_rd == REG_ADDR_W'(i))
          count[i] <= SB_CNT_W'(LOAD_LATENCY);
        else if (count[i] != '0)
          count[i] <= count[i] - 1'b1;
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int unsigned i = 0; i < REG_COUNT; i++) busy[i] = (count[i] != '0);
    busy[0] = 1'b0;
  end

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// Load-use stall detection, branch flush sequencing and stall statistics
// around a per-register scoreboard.
module scoreboard_hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_COUNT    = REG_COUNT_DEF,
  parameter int unsigned REG_ADDR_W   = REG_ADDR_W_DEF,
  parameter int unsigned LOAD_LATENCY = LOAD_LATENCY_DEF,
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int unsigned STALL_CNT_W  = STALL_CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic                   id_mem_read,
  input  logic [REG_ADDR_W-1:0]  id_rd,
  input  logic [REG_ADDR_W-1:0]  IF_ID_rs,
  input  logic [REG_ADDR_W-1:0]  IF_ID_rt,
  input  logic [1:0]             branch,
  input  logic                   equal,
  output logic                   pc_write,
  output logic                   IF_ID_write,
  output logic                   mux_hz_unit,
  output logic                   flush,
  output logic [STALL_CNT_W-1:0] stall_count,
  output logic [REG_COUNT-1:0]   busy
);

  logic [0:0] state;
  logic [1:0] flush_cnt;
  logic       stall;
  logic       taken;
  logic       load_en;

  hazard_scoreboard #(
    .REG_COUNT   (REG_COUNT),
    .REG_ADDR_W  (REG_ADDR_W),
    .LOAD_LATENCY(LOAD_LATENCY)
  ) u_scoreboard (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_en(load_en),
    .load_rd(id_rd),
    .busy   (busy)
  );

  always_comb begin
    stall = id_valid && (((IF_ID_rs != '0) && busy[IF_ID_rs]) ||
                         ((IF_ID_rt != '0) && busy[IF_ID_rt]));
    taken = id_valid && !stall &&
            (((branch == BR_BEQ) && equal) ||
             ((branch == BR_BNE) && !equal) ||
             (branch == BR_JUMP));
    // Loads only issue from IDLE; a flushed slot never reserves a register.
    load_en = id_valid && id_mem_read && !stall && (state == ST_IDLE) &&
              (id_rd != '0);
    flush       = (state == ST_FLUSH) ? 1'b1 : taken;
    pc_write    = !stall;
    IF_ID_write = !stall;
    mux_hz_unit = !stall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      flush_cnt <= '0;
    end else if (state == ST_IDLE) begin
      if (taken && (FLUSH_CYCLES > 1)) begin
        state     <= ST_FLUSH;
        flush_cnt <= 2'(FLUSH_CYCLES - 1);
      end
    end else begin
      if (flush_cnt <= 2'd1) begin
        state     <= ST_IDLE;
        flush_cnt <= '0;
      end else begin
        flush_cnt <= flush_cnt - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_count <= '0;
    else if (stall && (stall_count != '1))
      stall_count <= stall_count + 1'b1;
  end

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Directed checks of the hazard unit using two instances: a (LOAD_LATENCY=1,
// FLUSH_CYCLES=2) and b (LOAD_LATENCY=3, FLUSH_CYCLES=1) on shared inputs.
module tb_scoreboard_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_mem_read, equal;
  logic [4:0]  id_rd, rs, rt;
  logic [1:0]  branch;

  logic        a_pcw, a_ifw, a_mux, a_flush;
  logic [15:0] a_sc;
  logic [31:0] a_busy;
  logic        b_pcw, b_ifw, b_mux, b_flush;
  logic [15:0] b_sc;
  logic [31:0] b_busy;

  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  scoreboard_hazard_unit #(
    .REG_COUNT(32), .REG_ADDR_W(5), .LOAD_LATENCY(1), .FLUSH_CYCLES(2), .STALL_CNT_W(16)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_mem_read(id_mem_read),
    .id_rd(id_rd), .IF_ID_rs(rs), .IF_ID_rt(rt), .branch(branch), .equal(equal),
    .pc_write(a_pcw), .IF_ID_write(a_ifw), .mux_hz_unit(a_mux), .flush(a_flush),
    .stall_count(a_sc), .busy(a_busy)
  );

  scoreboard_hazard_unit #(
    .REG_COUNT(32), .REG_ADDR_W(5), .LOAD_LATENCY(3), .FLUSH_CYCLES(1), .STALL_CNT_W(16)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_mem_read(id_mem_read),
    .id_rd(id_rd), .IF_ID_rs(rs), .IF_ID_rt(rt), .branch(branch), .equal(equal),
    .pc_write(b_pcw), .IF_ID_write(b_ifw), .mux_hz_unit(b_mux), .flush(b_flush),
    .stall_count(b_sc), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic mr, input logic [4:0] rd_i,
                       input logic [4:0] rs_i, input logic [4:0] rt_i,
                       input logic [1:0] br, input logic eq);
    id_valid = v; id_mem_read = mr; id_rd = rd_i;
    rs = rs_i; rt = rt_i; branch = br; equal = eq;
    #1;
  endtask

  task automatic pulse_reset();
    drive(0, 0, 0, 0, 0, 2'b00, 0);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 2'b00, 0);
    tick();
    tick();
    chk("rst_pc_write", 32'(a_pcw), 32'd1);
    chk("rst_if_id_write", 32'(a_ifw), 32'd1);
    chk("rst_mux", 32'(a_mux), 32'd1);
    chk("rst_flush", 32'(a_flush), 32'd0);
    chk("rst_stall_count", 32'(a_sc), 32'd0);
    chk("rst_busy", a_busy, 32'd0);
    rst_n = 1'b1;

    // Load-use with latency 1 (instance a)
    drive(1, 1, 8, 0, 0, 2'b00, 0);
    chk("ll1_load_nostall", 32'(a_pcw), 32'd1);
    tick();
    drive(1, 0, 0, 8, 0, 2'b00, 0);
    chk("ll1_busy8", a_busy, 32'h0000_0100);
    chk("ll1_pc_write", 32'(a_pcw), 32'd0);
    chk("ll1_if_id_write", 32'(a_ifw), 32'd0);
    chk("ll1_mux", 32'(a_mux), 32'd0);
    tick();
    chk("ll1_release", 32'(a_pcw), 32'd1);
    chk("ll1_stall_count", 32'(a_sc), 32'd1);
    chk("ll1_busy_clear", a_busy, 32'd0);
    tick();

    // Load-use with latency 3 on rt (instance b)
    pulse_reset();
    drive(1, 1, 5, 0, 0, 2'b00, 0);
    tick();
    drive(1, 0, 0, 0, 5, 2'b00, 0);
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("ll3_stall_c%0d", k), 32'(b_pcw), 32'd0);
      chk($sformatf("ll3_busy5_c%0d", k), 32'(b_busy[5]), 32'd1);
      tick();
    end
    chk("ll3_release", 32'(b_pcw), 32'd1);
    chk("ll3_busy_clear", b_busy, 32'd0);
    chk("ll3_stall_count", 32'(b_sc), 32'd3);
    tick();

    // Register 0 is never busy
    pulse_reset();
    drive(1, 1, 0, 0, 0, 2'b00, 0);
    tick();
    drive(1, 0, 0, 0, 0, 2'b00, 0);
    chk("r0_no_stall", 32'(a_pcw), 32'd1);
    chk("r0_busy_a", a_busy, 32'd0);
    chk("r0_busy_b", b_busy, 32'd0);
    tick();
    chk("r0_stall_count", 32'(a_sc), 32'd0);

    // Two-cycle flush; jump and load during FLUSH ignored (instance a)
    pulse_reset();
    drive(1, 0, 0, 0, 0, 2'b10, 0);
    chk("fl_bne_cycle1", 32'(a_flush), 32'd1);
    tick();
    drive(1, 1, 9, 0, 0, 2'b11, 0);
    chk("fl_hold_cycle2", 32'(a_flush), 32'd1);
    tick();
    drive(1, 0, 0, 0, 0, 2'b00, 0);
    chk("fl_done_cycle3", 32'(a_flush), 32'd0);
    chk("fl_load_ignored", a_busy, 32'd0);
    tick();

    // Branch waits for a busy operand before flushing
    pulse_reset();
    drive(1, 1, 3, 0, 0, 2'b00, 0);
    tick();
    drive(1, 0, 0, 3, 0, 2'b01, 1);
    chk("br_stall_a", 32'(a_pcw), 32'd0);
    chk("br_noflush_a", 32'(a_flush), 32'd0);
    tick();
    chk("br_released_a", 32'(a_pcw), 32'd1);
    chk("br_flush_a", 32'(a_flush), 32'd1);
    chk("br_stall_b", 32'(b_pcw), 32'd0);
    chk("br_noflush_b", 32'(b_flush), 32'd0);
    tick();
    drive(1, 0, 0, 0, 0, 2'b00, 0);
    chk("br_flush_hold_a", 32'(a_flush), 32'd1);
    tick();

    // Asynchronous reset in the middle of a 3-cycle stall (instance b)
    pulse_reset();
    drive(1, 1, 5, 0, 0, 2'b00, 0);
    tick();
    drive(1, 0, 0, 0, 5, 2'b00, 0);
    chk("ar_stall1", 32'(b_pcw), 32'd0);
    tick();
    chk("ar_stall2", 32'(b_pcw), 32'd0);
    chk("ar_count_before", 32'(b_sc), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_pc_write", 32'(b_pcw), 32'd1);
    chk("ar_if_id_write", 32'(b_ifw), 32'd1);
    chk("ar_mux", 32'(b_mux), 32'd1);
    chk("ar_stall_count", 32'(b_sc), 32'd0);
    chk("ar_busy", b_busy, 32'd0);
    chk("ar_flush", 32'(b_flush), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("ar_post_unstalled", 32'(b_pcw), 32'd1);
    tick();
    chk("ar_post_count", 32'(b_sc), 32'd0);

    $display("%0d/%0d checks passed", passed, passed + failed);
    $finish;
  end

endmodule
